// File: rtl/rom_mac_seq_if.sv
// Job/result handshake and ROM-stage address/product bus for rom_mac_seq.
interface rom_mac_seq_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + ADDR_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_b;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] addr_1;
  logic [ADDR_WIDTH-1:0] addr_2;
  logic [DATA_WIDTH-1:0] prod_in;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  result;

  modport master (
    output start, base_a, base_b, len, prod_in, res_ready,
    input  addr_1, addr_2, busy, res_valid, result
  );

  modport slave (
    input  start, base_a, base_b, len, prod_in, res_ready,
    output addr_1, addr_2, busy, res_valid, result
  );
endinterface

// File: rtl/rom_mac_seq.sv
// Sequencer that walks two ROM address streams and accumulates the products
// returned by the ROM stage one cycle later, then presents the sum.
module rom_mac_seq #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  rom_mac_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_a_q;
  logic [ADDR_WIDTH-1:0] base_b_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   i_q;
  logic [ADDR_WIDTH-1:0] addr_1_q;
  logic [ADDR_WIDTH-1:0] addr_2_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  result_q;
  logic                  pend_q;
  logic                  busy_q;
  logic                  res_valid_q;

  logic [ADDR_WIDTH:0]   i_d;
  logic [ADDR_WIDTH-1:0] addr_1_d;
  logic [ADDR_WIDTH-1:0] addr_2_d;
  logic [ACC_WIDTH-1:0]  acc_d;

  // Address sums wrap naturally at the address width.
  assign i_d      = i_q + (ADDR_WIDTH+1)'(1);
  assign addr_1_d = base_a_q + ADDR_WIDTH'(i_q);
  assign addr_2_d = base_b_q + ADDR_WIDTH'(i_q);
  assign acc_d    = acc_q + ACC_WIDTH'(bus.prod_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_a_q    <= '0;
      base_b_q    <= '0;
      len_q       <= '0;
      i_q         <= '0;
      addr_1_q    <= '0;
      addr_2_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            i_q    <= '0;
            pend_q <= 1'b0;
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              result_q    <= '0;
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              base_a_q <= bus.base_a;
              base_b_q <= bus.base_b;
              len_q    <= bus.len;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          addr_1_q <= addr_1_d;
          addr_2_q <= addr_2_d;
          i_q      <= i_d;
          pend_q   <= 1'b1;
          if (pend_q) acc_q <= acc_d;
          if (i_d == len_q) state_q <= DRAIN;
        end
        // Absorb the last in-flight product, then publish the sum.
        DRAIN: begin
          if (pend_q) begin
            acc_q  <= acc_d;
            pend_q <= 1'b0;
          end else begin
            result_q    <= acc_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr_1    = addr_1_q;
  assign bus.addr_2    = addr_2_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;

endmodule

// File: doc/rom_mac_seq.md
ROM_MAC_SEQ -- requirements
Module: rom_mac_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width of the product word consumed from the ROM stage.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the width of each ROM address.
REQ-003 Parameter ACC_WIDTH, default DATA_WIDTH+ADDR_WIDTH, SHALL set the accumulator and result width.
REQ-004 clk  input  1  SHALL be the single clock; all block state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 start  input  1  SHALL request a new job; sampled only in IDLE.
REQ-007 base_a  input  ADDR_WIDTH  SHALL give the first address of operand stream A, captured on an accepted start.
REQ-008 base_b  input  ADDR_WIDTH  SHALL give the first address of operand stream B, captured on an accepted start.
REQ-009 len  input  ADDR_WIDTH+1  SHALL give the number of address pairs (0..2^ADDR_WIDTH), captured on an accepted start.
REQ-010 addr_1  output  ADDR_WIDTH  SHALL drive the ROM stage's first address port.
REQ-011 addr_2  output  ADDR_WIDTH  SHALL drive the ROM stage's second address port.
REQ-012 prod_in  input  DATA_WIDTH  SHALL carry the ROM stage's product output (rom[addr_1]*rom[addr_2], truncated to DATA_WIDTH).
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 res_valid  output  1  SHALL flag a valid result.
REQ-015 res_ready  input  1  SHALL acknowledge the result.
REQ-016 result  output  ACC_WIDTH  SHALL carry the accumulated sum.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 with len>0 SHALL capture operands, clear accumulator, set index i=0, go to RUN next cycle.
REQ-019 IDLE: start=1 with len=0 SHALL clear accumulator and go directly to DONE with result 0.
REQ-020 RUN: each cycle SHALL register addr_1=(base_a+i) mod 2^ADDR_WIDTH, addr_2=(base_b+i) mod 2^ADDR_WIDTH, then increment i; address wrap-around past 2^ADDR_WIDTH-1 to 0 is required behaviour.
REQ-021 ROM stage latches addresses on the falling clk edge, so the product for a pair driven after rising edge k SHALL be sampled from prod_in at rising edge k+1 (one-cycle latency).
REQ-022 A one-bit pending flag SHALL mark that the previous cycle issued a pair; when set, prod_in SHALL be zero-extended and added to the accumulator.
REQ-023 After issuing pair len-1, FSM SHALL go to DRAIN; DRAIN SHALL accumulate the last product and go to DONE.
REQ-024 Accumulator SHALL wrap modulo 2^ACC_WIDTH; with defaults no overflow is possible (max 64*15 < 2^10).
REQ-025 DONE: res_valid=1 and result SHALL hold stable until res_valid&&res_ready; on that cycle FSM SHALL return to IDLE, res_valid drops next cycle.
REQ-026 start asserted outside IDLE SHALL be ignored, without queuing.
REQ-027 addr_1/addr_2 SHALL hold their last value outside RUN.
REQ-028 Job of len=N (N>0) SHALL show res_valid exactly N+2 cycles after the start-accepting edge.
REQ-029 Back-to-back: start asserted on the cycle after return to IDLE SHALL be accepted normally.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, busy=0, res_valid=0, result=0, accumulator=0, i=0, pending=0, addr_1=0, addr_2=0, overriding all other inputs.
REQ-031 Reset mid-job (RUN, DRAIN or DONE) SHALL abort the job with no result presented.

Verification
(Bench ROM model: rom[i]=i mod 16, DATA_WIDTH=4, product truncated to 4 bits.)
REQ-032 start, base_a=2, base_b=3, len=2 -> pairs (2,3),(3,4); products 6,12; res_valid 4 cycles after start, result=18.
REQ-033 start, base_a=63, base_b=0, len=2 -> addr_1 sequence 63,0; addr_2 0,1; products 15*0=0, 0*1=0; result=0 (wrap).
REQ-034 start, len=0 -> DONE next cycle, result=0, addr_1/addr_2 unchanged.
REQ-035 res_ready held low 5 cycles in DONE -> result and res_valid stable; start pulses during this time ignored; res_ready=1 -> IDLE.
REQ-036 rst=1 during RUN of len=10 job -> next cycle busy=0, res_valid=0, result=0; new job base_a=1, base_b=1, len=1 -> result=1.
REQ-037 start, base_a=0, base_b=0, len=64 -> result = sum over i of (i mod 16)^2 mod 16 = 4*(0+1+4+9+0+9+4+1+0+1+4+9+0+9+4+1) = 224, res_valid at cycle 66.
